// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path: FSM states,
// parity encodings and the mid-bit sample points derived from the oversample ratio.
package uart_rx_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_OVS    = 16;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   // Three consecutive ticks centred on the bit middle feed the majority vote.
   function automatic int mid_lo(input int ovs);
      return ovs / 2 - 1;
   endfunction

   function automatic int mid(input int ovs);
      return ovs / 2;
   endfunction

   function automatic int mid_hi(input int ovs);
      return ovs / 2 + 1;
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Line-side inputs and consumer-side outputs of the UART receiver.
// The receiver takes the slave view; the line/consumer side takes the master view.
interface uart_rx_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              rx_in;
   logic              par_en;
   logic              par_typ;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              par_err;
   logic              frm_err;
   logic              busy;

   modport master (
      output rx_in, par_en, par_typ,
      input  rx_data, rx_valid, par_err, frm_err, busy
   );

   modport slave (
      input  rx_in, par_en, par_typ,
      output rx_data, rx_valid, par_err, frm_err, busy
   );
endinterface

// File: rtl/uart_rx_sampler.sv
// Synchronizes rx_in, counts oversample ticks within a bit and majority-votes three mid-bit samples.
// rx_s lags rx_in by 2 clk; vote is valid on the OVS/2+1 tick; no backpressure (tick-paced).
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int OVS = DEF_OVS
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic rx_in,
   input  logic cnt_clr,
   output logic rx_s,
   output logic bit_vote,
   output logic vote_strobe,
   output logic bit_end
);

   localparam int             TW     = $clog2(OVS);
   localparam logic [TW-1:0]  T_LO   = TW'(mid_lo(OVS));
   localparam logic [TW-1:0]  T_MID  = TW'(mid(OVS));
   localparam logic [TW-1:0]  T_HI   = TW'(mid_hi(OVS));
   localparam logic [TW-1:0]  T_LAST = TW'(OVS - 1);

   logic [1:0]    sync_q, sync_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          s0_q, s0_d;
   logic          s1_q, s1_d;

   assign rx_s = sync_q[1];

   always_comb begin
      sync_d     = {sync_q[0], rx_in};
      tick_cnt_d = tick_cnt_q;
      s0_d       = s0_q;
      s1_d       = s1_q;
      if (tick) begin
         if (cnt_clr || tick_cnt_q == T_LAST) begin
            tick_cnt_d = '0;
         end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
         end
         if (tick_cnt_q == T_LO) begin
            s0_d = rx_s;
         end
         if (tick_cnt_q == T_MID) begin
            s1_d = rx_s;
         end
      end
   end

   // Third sample is the live rx_s, so the vote lands in the same cycle as that tick.
   assign bit_vote    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
   assign vote_strobe = tick && (tick_cnt_q == T_HI);
   assign bit_end     = tick && (tick_cnt_q == T_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q     <= 2'b11;
         tick_cnt_q <= '0;
         s0_q       <= 1'b1;
         s1_q       <= 1'b1;
      end else begin
         sync_q     <= sync_d;
         tick_cnt_q <= tick_cnt_d;
         s0_q       <= s0_d;
         s1_q       <= s1_d;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, LSB-first data capture, optional parity, stop check.
// Result pulses 1 clk after the stop-bit vote (~1+DATA_W+par_en+0.5 bits after start); no backpressure.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int OVS    = DEF_OVS
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           tick,
   uart_rx_ctrl_if.slave  rxif
);

   localparam int            BW       = $clog2(DATA_W);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   rx_state_t         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic              perr_q, perr_d;
   logic              par_en_q, par_en_d;
   logic              par_typ_q, par_typ_d;
   logic              rx_valid_q, rx_valid_d;
   logic              par_err_q, par_err_d;
   logic              frm_err_q, frm_err_d;

   logic rx_s;
   logic bit_vote;
   logic vote_strobe;
   logic bit_end;

   uart_rx_sampler #(
      .OVS (OVS)
   ) u_sampler (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .rx_in       (rxif.rx_in),
      .cnt_clr     (state_q == IDLE),
      .rx_s        (rx_s),
      .bit_vote    (bit_vote),
      .vote_strobe (vote_strobe),
      .bit_end     (bit_end)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      bit_cnt_d  = bit_cnt_q;
      perr_d     = perr_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      rx_valid_d = 1'b0;
      par_err_d  = 1'b0;
      frm_err_d  = 1'b0;

      case (state_q)
         IDLE: begin
            // Frame config is frozen here so mid-frame changes cannot corrupt it.
            if (tick && !rx_s) begin
               state_d   = START;
               par_en_d  = rxif.par_en;
               par_typ_d = rxif.par_typ;
               perr_d    = 1'b0;
            end
         end
         START: begin
            if (vote_strobe && bit_vote) begin
               state_d = IDLE;
            end else if (bit_end) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (vote_strobe) begin
               shift_d = {bit_vote, shift_q[DATA_W-1:1]};
            end
            if (bit_end) begin
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (vote_strobe) begin
               perr_d = bit_vote != ((^shift_q) ^ (par_typ_q == PAR_ODD));
            end
            if (bit_end) begin
               state_d = STOP;
            end
         end
         STOP: begin
            // Leave at the mid-bit vote so a following start edge is not missed.
            if (vote_strobe) begin
               state_d   = IDLE;
               rx_data_d = shift_q;
               if (!bit_vote) begin
                  frm_err_d = 1'b1;
               end else if (perr_q) begin
                  par_err_d = 1'b1;
               end else begin
                  rx_valid_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         rx_data_q  <= '0;
         bit_cnt_q  <= '0;
         perr_q     <= 1'b0;
         par_en_q   <= 1'b0;
         par_typ_q  <= PAR_EVEN;
         rx_valid_q <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         bit_cnt_q  <= bit_cnt_d;
         perr_q     <= perr_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         rx_valid_q <= rx_valid_d;
         par_err_q  <= par_err_d;
         frm_err_q  <= frm_err_d;
      end
   end

   assign rxif.rx_data  = rx_data_q;
   assign rxif.rx_valid = rx_valid_q;
   assign rxif.par_err  = par_err_q;
   assign rxif.frm_err  = frm_err_q;
   assign rxif.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed and random frames, expected results queued at send time
// and matched by an independent monitor against every output pulse.
module tb_uart_rx_ctrl;
   import uart_rx_pkg::*;

   localparam int DATA_W = 8;
   localparam int OVS    = 16;

   localparam int K_VALID = 0;
   localparam int K_PERR  = 1;
   localparam int K_FERR  = 2;

   logic clk  = 1'b0;
   logic rst  = 1'b0;
   logic tick = 1'b0;

   uart_rx_ctrl_if #(.DATA_W(DATA_W)) rxif ();

   uart_rx_ctrl #(
      .DATA_W (DATA_W),
      .OVS    (OVS)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .rxif (rxif)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                kind;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   tick_div = 4;
   int   cyc_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Tick generator: one clk wide every tick_div clocks, or held high when tick_div is 1.
   initial begin
      forever begin
         @(negedge clk);
         cyc_cnt++;
         tick = (tick_div <= 1) ? 1'b1 : (cyc_cnt % tick_div == 0);
      end
   end

   // Monitor: every result pulse must be one-hot and match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst && (rxif.rx_valid || rxif.par_err || rxif.frm_err)) begin
         exp_t e;
         int   act_kind;
         check("pulse_onehot", 32'(rxif.rx_valid) + 32'(rxif.par_err) + 32'(rxif.frm_err), 32'd1);
         act_kind = rxif.rx_valid ? K_VALID : (rxif.par_err ? K_PERR : K_FERR);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse_kind", 32'(act_kind), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("result_kind", 32'(act_kind), 32'(e.kind));
            check("rx_data", 32'(rxif.rx_data), 32'(e.data));
         end
      end
   end

   task automatic wait_ticks(input int n);
      int k = 0;
      while (k < n) begin
         @(posedge clk);
         if (tick) k++;
      end
      #1;
   endtask

   task automatic line_idle(input int n);
      rxif.rx_in = 1'b1;
      wait_ticks(n);
   endtask

   // Sends one frame. par_flip inverts the correct parity bit; glitch_bit inverts the line for one
   // tick mid-bit; abort_bit pulls reset mid-way through that data bit and ends the frame there.
   task automatic send_frame(input logic [DATA_W-1:0] d, input bit pe, input bit pt,
                             input bit par_flip, input bit stop_v,
                             input int glitch_bit, input int abort_bit);
      logic good_pb;
      logic pb;
      exp_t e;
      good_pb = pt ? ~(^d) : (^d);
      pb      = good_pb ^ par_flip;
      rxif.par_en  = pe;
      rxif.par_typ = pt;
      if (abort_bit < 0) begin
         e.data = d;
         if (!stop_v)                 e.kind = K_FERR;
         else if (pe && pb != good_pb) e.kind = K_PERR;
         else                          e.kind = K_VALID;
         exp_q.push_back(e);
      end
      rxif.rx_in = 1'b0;
      wait_ticks(OVS);
      rxif.par_en  = 1'($urandom);
      rxif.par_typ = 1'($urandom);
      for (int i = 0; i < DATA_W; i++) begin
         rxif.rx_in = d[i];
         if (i == abort_bit) begin
            wait_ticks(OVS / 2);
            rst = 1'b0;
            #1;
            check("abort_rx_data", 32'(rxif.rx_data), 32'd0);
            check("abort_busy", 32'(rxif.busy), 32'd0);
            check("abort_pulses", 32'({rxif.rx_valid, rxif.par_err, rxif.frm_err}), 32'd0);
            rxif.rx_in = 1'b1;
            return;
         end
         if (i == glitch_bit) begin
            wait_ticks(OVS / 2);
            rxif.rx_in = ~d[i];
            wait_ticks(1);
            rxif.rx_in = d[i];
            wait_ticks(OVS / 2 - 1);
         end else begin
            wait_ticks(OVS);
         end
      end
      if (pe) begin
         rxif.rx_in = pb;
         wait_ticks(OVS);
      end
      rxif.rx_in = stop_v;
      wait_ticks(OVS);
      rxif.rx_in = 1'b1;
   endtask

   task automatic random_frames(input int n);
      for (int f = 0; f < n; f++) begin
         logic [DATA_W-1:0] d;
         bit pe, pt, flip, stop_v;
         d      = DATA_W'($urandom);
         pe     = 1'($urandom);
         pt     = 1'($urandom);
         flip   = pe && ($urandom_range(0, 4) == 0);
         stop_v = ($urandom_range(0, 7) != 0);
         send_frame(d, pe, pt, flip, stop_v, -1, -1);
         if (!stop_v) line_idle(2 * OVS);
         else         line_idle($urandom_range(0, OVS));
      end
   endtask

   initial begin
      rxif.rx_in   = 1'b1;
      rxif.par_en  = 1'b0;
      rxif.par_typ = PAR_EVEN;
      repeat (3) @(negedge clk);
      check("reset_rx_data", 32'(rxif.rx_data), 32'd0);
      check("reset_rx_valid", 32'(rxif.rx_valid), 32'd0);
      check("reset_par_err", 32'(rxif.par_err), 32'd0);
      check("reset_frm_err", 32'(rxif.frm_err), 32'd0);
      check("reset_busy", 32'(rxif.busy), 32'd0);
      rst = 1'b1;
      line_idle(OVS);

      send_frame(8'hA5, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, -1);
      line_idle(OVS);
      check("a5_busy_after", 32'(rxif.busy), 32'd0);

      send_frame(8'h3C, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, -1);
      line_idle(OVS);
      send_frame(8'h3C, 1'b1, PAR_EVEN, 1'b1, 1'b1, -1, -1);
      line_idle(OVS);

      rxif.rx_in = 1'b0;
      wait_ticks(4);
      check("false_start_busy_high", 32'(rxif.busy), 32'd1);
      rxif.rx_in = 1'b1;
      wait_ticks(OVS / 2 + 2);
      check("false_start_busy_low", 32'(rxif.busy), 32'd0);
      line_idle(OVS);

      send_frame(8'h55, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, -1);
      line_idle(2 * OVS);
      check("break_recovered_busy", 32'(rxif.busy), 32'd0);
      send_frame(8'h0F, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, -1);
      line_idle(OVS);

      send_frame(8'h00, 1'b0, PAR_EVEN, 1'b0, 1'b1, 3, -1);
      line_idle(OVS);

      send_frame(8'h7E, 1'b1, PAR_ODD, 1'b0, 1'b1, -1, -1);
      line_idle(OVS);
      send_frame(8'hC3, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 4);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      line_idle(OVS);

      send_frame(8'h81, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, -1);
      line_idle(OVS);
      send_frame(8'h12, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, -1);
      send_frame(8'h34, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, -1);
      line_idle(OVS);

      random_frames(30);

      tick_div = 1;
      line_idle(OVS);
      random_frames(10);
      line_idle(2 * OVS);

      begin
         int budget = 0;
         while (exp_q.size() != 0 && budget < 5000) begin
            @(negedge clk);
            budget++;
         end
      end
      check("expected_queue_drained", 32'(exp_q.size()), 32'd0);
      check("final_busy", 32'(rxif.busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
